// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, FSM encoding, segment order and paddle helper for the Pong engine
package pong_pkg;
  localparam int HBP        = 144;
  localparam int VBP        = 31;
  localparam int FIELD_L    = HBP + 50;
  localparam int FIELD_R    = 733;
  localparam int FIELD_T    = VBP + 50;
  localparam int FIELD_B    = 460;
  localparam int PAD_L_FACE = 213;
  localparam int PAD_R_FACE = 719;
  localparam int PAD_H      = 100;
  localparam int PAD_MIN    = FIELD_T;
  localparam int PAD_MAX    = FIELD_B - PAD_H + 1;
  localparam int BALL_CX    = 464;
  localparam int BALL_CY    = 271;
  localparam int PAD_C      = 221;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;
  typedef enum int {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_bit_t;
  // Conflicting or absent buttons leave the paddle still; moves past a limit stop on it.
  function automatic logic [9:0] paddle_next(input logic [9:0] pos, input logic up,
                                             input logic dn, input int step);
    logic signed [10:0] p;
    p = $signed({1'b0, pos});
    if (up && !dn) p = p - 11'(step);
    else if (dn && !up) p = p + 11'(step);
    return p < PAD_MIN ? 10'(PAD_MIN) : p > PAD_MAX ? 10'(PAD_MAX) : p[9:0];
  endfunction
endpackage

// File: rtl/pong_seg7_enc.sv
// pong_seg7_enc: decimal digit to active-high 7-segment pattern (bit 0 = segment a)
module pong_seg7_enc (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine: once-per-frame Pong game logic driving ball, paddles and score patterns
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV     = 416800,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_TICKS  = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       btn_start,
  output logic [9:0] ballx,
  output logic [9:0] bally,
  output logic [9:0] l_pos,
  output logic [9:0] r_pos,
  output logic [6:0] score_l,
  output logic [6:0] score_r,
  output logic       game_over
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_TICKS + 1);
  logic [4:0] sync1, sync2;
  logic start_q, start_pend, start_edge, go, tick;
  logic [CW-1:0] cnt;
  logic [SW-1:0] serve_cnt, serve_cnt_n;
  state_t state, state_n;
  logic dx, dy, dx_n, dy_n;
  logic [3:0] dig_l, dig_r, dig_l_n, dig_r_n;
  logic [9:0] ballx_n, bally_n, l_pos_n, r_pos_n;
  logic signed [10:0] bx, by, lp, rp, nx, ny;
  logic hit_l, hit_r, top, bot;

  assign tick       = cnt == CW'(TICK_DIV - 1);
  assign start_edge = sync2[4] & ~start_q;
  assign go         = start_pend | start_edge;

  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      sync1      <= '0;
      sync2      <= '0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= {btn_start, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};
      sync2      <= sync1;
      start_q    <= sync2[4];
      start_pend <= ~tick & (start_pend | start_edge);
      cnt        <= tick ? '0 : cnt + 1'b1;
    end

  // Signed 11-bit copies keep the edge tests free of unsigned wraparound.
  assign bx    = $signed({1'b0, ballx});
  assign by    = $signed({1'b0, bally});
  assign lp    = $signed({1'b0, l_pos});
  assign rp    = $signed({1'b0, r_pos});
  assign nx    = dx ? bx + 11'(BALL_SPEED) : bx - 11'(BALL_SPEED);
  assign ny    = dy ? by + 11'(BALL_SPEED) : by - 11'(BALL_SPEED);
  assign top   = ny - 4 < FIELD_T;
  assign bot   = ny + 5 > FIELD_B;
  assign hit_l = !dx && bx - 4 > PAD_L_FACE && nx - 4 <= PAD_L_FACE &&
                 by + 5 >= lp && by - 4 <= lp + PAD_H - 1;
  assign hit_r = dx && bx + 5 < PAD_R_FACE && nx + 5 >= PAD_R_FACE &&
                 by + 5 >= rp && by - 4 <= rp + PAD_H - 1;

  always_comb begin
    state_n     = state;
    ballx_n     = ballx;
    bally_n     = bally;
    dx_n        = dx;
    dy_n        = dy;
    dig_l_n     = dig_l;
    dig_r_n     = dig_r;
    serve_cnt_n = serve_cnt;
    l_pos_n     = state == OVER ? l_pos : paddle_next(l_pos, sync2[0], sync2[1], PADDLE_SPEED);
    r_pos_n     = state == OVER ? r_pos : paddle_next(r_pos, sync2[2], sync2[3], PADDLE_SPEED);
    case (state)
      IDLE: if (go) begin
        state_n     = SERVE;
        serve_cnt_n = '0;
      end
      SERVE: begin
        ballx_n     = 10'(BALL_CX);
        bally_n     = 10'(BALL_CY);
        dy_n        = 1'b1;
        serve_cnt_n = serve_cnt + 1'b1;
        if (serve_cnt == SW'(SERVE_TICKS - 1)) state_n = PLAY;
      end
      PLAY: begin
        bally_n = top ? 10'(FIELD_T + 4) : bot ? 10'(FIELD_B - 5) : ny[9:0];
        dy_n    = top | (dy & ~bot);
        // A miss leaves x in place; dx then records the serve direction, toward the loser.
        if (hit_l) begin
          ballx_n = 10'(PAD_L_FACE + 5);
          dx_n    = 1'b1;
        end else if (hit_r) begin
          ballx_n = 10'(PAD_R_FACE - 6);
          dx_n    = 1'b0;
        end else if (nx - 4 < FIELD_L) begin
          dx_n    = 1'b0;
          state_n = POINT;
        end else if (nx + 5 > FIELD_R) begin
          dx_n    = 1'b1;
          state_n = POINT;
        end else ballx_n = nx[9:0];
      end
      POINT: begin
        ballx_n     = 10'(BALL_CX);
        bally_n     = 10'(BALL_CY);
        dig_l_n     = dx && dig_l != 4'd9 ? dig_l + 4'd1 : dig_l;
        dig_r_n     = !dx && dig_r != 4'd9 ? dig_r + 4'd1 : dig_r;
        serve_cnt_n = '0;
        state_n     = (dx ? dig_l_n : dig_r_n) == 4'(WIN_SCORE) ? OVER : SERVE;
      end
      OVER: begin
        ballx_n = 10'(BALL_CX);
        bally_n = 10'(BALL_CY);
        if (go) begin
          dig_l_n     = '0;
          dig_r_n     = '0;
          dx_n        = 1'b1;
          serve_cnt_n = '0;
          state_n     = SERVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      state     <= IDLE;
      ballx     <= 10'(BALL_CX);
      bally     <= 10'(BALL_CY);
      l_pos     <= 10'(PAD_C);
      r_pos     <= 10'(PAD_C);
      dx        <= 1'b1;
      dy        <= 1'b1;
      dig_l     <= '0;
      dig_r     <= '0;
      serve_cnt <= '0;
      game_over <= 1'b0;
    end else if (tick) begin
      state     <= state_n;
      ballx     <= ballx_n;
      bally     <= bally_n;
      l_pos     <= l_pos_n;
      r_pos     <= r_pos_n;
      dx        <= dx_n;
      dy        <= dy_n;
      dig_l     <= dig_l_n;
      dig_r     <= dig_r_n;
      serve_cnt <= serve_cnt_n;
      game_over <= state_n == OVER;
    end

  pong_seg7_enc u_seg_l (.digit(dig_l), .seg(score_l));
  pong_seg7_enc u_seg_r (.digit(dig_r), .seg(score_r));
endmodule

// File: tb/tb_pong_game_engine.sv
// tb_pong_game_engine: random and directed play checked every tick against an integer game model
module tb_pong_game_engine;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;
  logic dclk = 1'b0, clr = 1'b1;
  logic btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0, btn_start = 1'b0;
  logic [9:0] ballx, bally, l_pos, r_pos;
  logic [6:0] score_l, score_r;
  logic game_over;
  int n_asrt = 0, n_fail = 0;
  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  int mbx, mby, mlp, mrp, mdx, mdy, msl, msr, mmode, mserve;
  bit ev_hit_r, ev_bot, seen1;

  pong_game_engine #(.TICK_DIV(8), .SERVE_TICKS(3)) dut (
    .dclk(dclk), .clr(clr),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .btn_start(btn_start),
    .ballx(ballx), .bally(bally), .l_pos(l_pos), .r_pos(r_pos),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 dclk = ~dclk;

  function automatic int clampp(int p);
    return p < 81 ? 81 : p > 361 ? 361 : p;
  endfunction

  function automatic int pdir(bit up, bit dn);
    return up == dn ? 0 : up ? -4 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mbx = 464; mby = 271; mlp = 221; mrp = 221;
    mdx = 1; mdy = 1; msl = 0; msr = 0; mmode = M_IDLE; mserve = 0;
  endtask

  // One game tick of the rules, on plain integers and drawn-span edges.
  task automatic model_step(bit lu, bit ld, bit ru, bit rd, bit st);
    int ox, oy, olp, orp, nx, ny;
    ox = mbx; oy = mby; olp = mlp; orp = mrp;
    ev_hit_r = 0; ev_bot = 0;
    if (mmode != M_OVER) begin
      mlp = clampp(mlp + pdir(lu, ld));
      mrp = clampp(mrp + pdir(ru, rd));
    end
    if (mmode == M_IDLE) begin
      if (st) begin mmode = M_SERVE; mserve = 0; end
    end else if (mmode == M_SERVE) begin
      mbx = 464; mby = 271; mdy = 1;
      mserve++;
      if (mserve == 3) mmode = M_PLAY;
    end else if (mmode == M_PLAY) begin
      nx = ox + 2 * mdx;
      ny = oy + 2 * mdy;
      if (ny - 4 < 81) begin mby = 85; mdy = 1; end
      else if (ny + 5 > 460) begin mby = 455; mdy = -1; ev_bot = 1; end
      else mby = ny;
      if (mdx < 0 && ox - 4 > 213 && nx - 4 <= 213 && oy + 5 >= olp && oy - 4 <= olp + 99) begin
        mbx = 218; mdx = 1;
      end else if (mdx > 0 && ox + 5 < 719 && nx + 5 >= 719 && oy + 5 >= orp && oy - 4 <= orp + 99) begin
        mbx = 713; mdx = -1; ev_hit_r = 1;
      end else if (nx - 4 < 194) begin
        mdx = -1; mmode = M_POINT;
      end else if (nx + 5 > 733) begin
        mdx = 1; mmode = M_POINT;
      end else mbx = nx;
    end else if (mmode == M_POINT) begin
      mbx = 464; mby = 271;
      if (mdx > 0) msl = msl < 9 ? msl + 1 : 9;
      else msr = msr < 9 ? msr + 1 : 9;
      mmode = (msl == 9 || msr == 9) ? M_OVER : M_SERVE;
      mserve = 0;
    end else begin
      mbx = 464; mby = 271;
      if (st) begin msl = 0; msr = 0; mdx = 1; mmode = M_SERVE; mserve = 0; end
    end
  endtask

  task automatic check_all();
    chk("ballx", ballx, mbx);
    chk("bally", bally, mby);
    chk("l_pos", l_pos, mlp);
    chk("r_pos", r_pos, mrp);
    chk("score_l", score_l, seg_tab[msl]);
    chk("score_r", score_r, seg_tab[msr]);
    chk("game_over", game_over, mmode == M_OVER);
  endtask

  // Buttons change just after a tick edge, so they are synchronised well before the next tick.
  task automatic tick(bit lu, bit ld, bit ru, bit rd, bit st);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; btn_start = st;
    repeat (3) @(posedge dclk);
    btn_start = 1'b0;
    repeat (5) @(posedge dclk);
    #1;
    model_step(lu, ld, ru, rd, st);
    check_all();
  endtask

  task automatic mid_reset();
    btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0; btn_start = 0;
    repeat (3) @(posedge dclk);
    #2 clr = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("tick_cnt", dut.cnt, 0);
    @(negedge dclk) clr = 1'b0;
  endtask

  initial begin
    mid_reset();
    for (int i = 0; i < 6; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("l_clamp_top", l_pos, 81);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("l_hold_both", l_pos, 81);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Right paddle follows the ball; left wanders randomly.
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           mby < mrp + 46, mby > mrp + 54, 1'b0);
      if (ev_hit_r) chk("r_hit_x", ballx, 713);
      if (ev_bot) chk("bottom_bounce_y", bally, 455);
    end
    mid_reset();
    // Right paddle parked at the top: every serve to the right becomes a point for the left.
    seen1 = 0;
    for (int i = 0; i < 2500 && mmode != M_OVER; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, i == 0);
      if (msl == 1 && !seen1) begin
        seen1 = 1;
        chk("first_point", score_l, 7'h06);
      end
    end
    chk("over_reached", game_over, 1);
    chk("over_score_l", score_l, 7'h6F);
    for (int i = 0; i < 6; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_score_l", score_l, 7'h3F);
    chk("restart_score_r", score_r, 7'h3F);
    chk("restart_over", game_over, 0);
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Game-logic stage directly upstream of the 640x480 VGA renderer.
- Advances Pong state once per video frame: paddle motion from buttons, ball motion, wall and paddle bounces, misses, scoring and the serve/game-over sequence.
- Drives ballx, bally, l_pos, r_pos and the 7-segment score patterns that the renderer consumes.
- All coordinates are in the renderer's counter space: hbp=144, vbp=31. The playfield interior is x 194..733, y 81..460.

Parameters:
- TICK_DIV, 416800, dclk cycles per game tick (800*521 = one frame).
- BALL_SPEED, 2, ball pixels per tick on each axis.
- PADDLE_SPEED, 4, paddle pixels per tick.
- SERVE_TICKS, 60, ticks the ball is held at centre before launch.
- WIN_SCORE, 9, score that ends the game (must be at most 9).

Ports:
- dclk  in  1  25 MHz pixel clock
- clr  in  1  reset
- btn_l_up  in  1  left paddle up, asynchronous raw button
- btn_l_dn  in  1  left paddle down, raw
- btn_r_up  in  1  right paddle up, raw
- btn_r_dn  in  1  right paddle down, raw
- btn_start  in  1  start/restart, raw
- ballx  out  10  ball centre x; drawn span is ballx-4..ballx+5
- bally  out  10  ball centre y; drawn span is bally-4..bally+5
- l_pos  out  10  left paddle top y; height 100; x span 199..213
- r_pos  out  10  right paddle top y; height 100; x span 719..733
- score_l  out  7  left score segments, active-high; bit 0 top, 1 top-right, 2 bottom-right, 3 bottom, 4 bottom-left, 5 top-left, 6 middle
- score_r  out  7  right score segments, same encoding
- game_over  out  1  high in state OVER

Behaviour:
- Reset: clr is asynchronous, active-high; clock is dclk.
- Values in reset: ballx=464, bally=271, l_pos=r_pos=221, both scores 0 (pattern 7'b0111111), game_over=0, state IDLE, dx=+1, dy=+1, tick counter 0.
- Outputs are registered.
- Input synchronisation: every button passes through a 2-FF synchroniser on dclk.
- btn_start is rising-edge detected after synchronisation. The edge is latched until the next tick.
- Tick generation: a counter runs 0..TICK_DIV-1. tick pulses for one cycle when the counter wraps.
- All game updates occur on the tick cycle. Outputs change on the dclk edge that ends the tick cycle.
- Paddles (all states except OVER):
  - up only: pos -= PADDLE_SPEED; down only: pos += PADDLE_SPEED.
  - up and down together, or neither: no move.
  - Clamp to 81..361. Moves that would cross a limit land exactly on the limit.
- FSM states:
  - IDLE: ball held at (464,271). Start edge -> SERVE with serve counter=0 and scores unchanged.
  - SERVE: ball held at centre; counter increments each tick. After SERVE_TICKS ticks -> PLAY. dx is the serve direction; dy=+1.
  - PLAY: next = pos ± BALL_SPEED. Checks are evaluated in the order below, one resolution per tick. Start edges are ignored.
    1. Top wall: next top (y-4) < 81 -> bally=85, dy=+1.
    2. Bottom wall: next bottom (y+5) > 460 -> bally=455, dy=-1.
    3. Left paddle: dx<0, current left edge > 213, next left edge <= 213, and bally+5 >= l_pos and bally-4 <= l_pos+99 -> ballx=218, dx=+1.
    4. Right paddle: dx>0, current right edge < 719, next right edge >= 719, and the same overlap test against r_pos -> ballx=713, dx=-1.
    5. Miss left: next left edge < 194 -> the right player scores; serve direction = -1 (toward the loser).
    6. Miss right: next right edge > 733 -> the left player scores; serve direction = +1.
    7. Otherwise the ball moves to the next position.
    - A corner case (wall plus paddle) applies the y and x resolutions together in the same tick.
  - POINT (lasts one tick): increment the scoring side's score, saturating at 9; recentre the ball.
    - Score == WIN_SCORE -> OVER; otherwise -> SERVE.
  - OVER: game_over=1; ball centred; paddles frozen.
    - Start edge -> scores cleared to 0, serve direction +1, -> SERVE.
- Score encoding is combinational from 4-bit registered digits:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any other digit value encodes to 00.
- Width rules:
  - Compute in 11-bit signed to avoid underflow at wall checks.
  - Outputs are always within the ranges above.
- Reset during any state returns immediately to the reset values. No partial frame update survives.

Decomposition:
- Shared package pong_pkg holds:
  - geometry constants: HBP, VBP, field edges 194/733/81/460, paddle faces 213/719, paddle height 100, ball centre 464/271, paddle centre 221;
  - FSM state encoding: IDLE, SERVE, PLAY, POINT, OVER;
  - the segment-bit order.
- One sub-module, pong_seg7_enc: 4-bit digit in, 7-bit pattern out. It is instantiated twice.

Test Plan:
- All benches use TICK_DIV=8 and SERVE_TICKS=3.
- Reset: assert clr mid-count -> ballx=464, bally=271, l_pos=r_pos=221, score_l=score_r=7'h3F, game_over=0, tick counter 0.
- Paddle clamp: hold btn_l_up 40 ticks -> l_pos reaches 81 and stays there. Hold btn_l_up and btn_l_dn together -> l_pos unchanged.
- Serve and wall bounce: press start, wait 3 ticks -> ballx moves +2/tick. When the ball bottom would exceed 460 -> bally=455, then decreasing.
- Paddle hit: r_pos=221, ball approaching at bally=271 -> ballx=713, dx reverses, score_r unchanged.
- Miss: move r_pos to 81 and let the ball pass at y>190 -> score_l becomes 7'h06, ball recentred, SERVE, then the ball travels right.
- Game over: drive left to 9 points -> score_l=7'h6F, game_over=1, paddles frozen. Press start -> both scores 7'h3F, game_over=0, SERVE.
